alu_issue: RTL and testbench

- Issue/sequencing stage directly upstream of `alu`.
- Accepts operation requests (operands, function select, tag) over a valid/ready handshake.
- Drives `inp_a`/`inp_b`/`fnct_sel` into the ALU and holds them until `alu_ack`, or until a timeout expires.
- Captures `out` and the cf/nf/zf/vf flags, then returns them to the requester as a tagged response with valid/ready.

---
 rtl/alu_issue.sv | 143 ++++++++++++++
 tb/tb_alu_issue.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// alu_issue : request/response sequencer that feeds one op at a time to the ALU
// Rev 1.0
// ============================================================================
module alu_issue #(
  parameter int              DATA_W      = 32,
  parameter int              SEL_W       = 9,
  parameter logic [SEL_W-1:0] IDLE_SEL   = 9'h100,
  parameter int              TAG_W       = 4,
  parameter int              TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [SEL_W-1:0]  req_fnct,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [DATA_W-1:0] inp_a,
  output logic [DATA_W-1:0] inp_b,
  output logic [SEL_W-1:0]  fnct_sel,
  input  logic              alu_ack,
  input  logic [DATA_W-1:0] out,
  input  logic              cf,
  input  logic              nf,
  input  logic              zf,
  input  logic              vf,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [3:0]        rsp_flags,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYC - 1);

  state_t            state_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [SEL_W-1:0]  sel_q;
  logic [TAG_W-1:0]  tag_q;
  logic [7:0]        cnt_q;
  logic              req_ready_q;
  logic              busy_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [3:0]        rsp_flags_q;
  logic [TAG_W-1:0]  rsp_tag_q;
  logic              rsp_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= IDLE_SEL;
      tag_q       <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            a_q         <= req_a;
            b_q         <= req_b;
            sel_q       <= req_fnct;
            tag_q       <= req_tag;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_EXEC;
          end
        end
        S_EXEC: begin
          cnt_q <= cnt_q + 8'd1;
          // An ack on the final allowed cycle still counts as a good result.
          if (alu_ack) begin
            rsp_data_q  <= out;
            rsp_flags_q <= {cf, nf, zf, vf};
            rsp_tag_q   <= tag_q;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            sel_q       <= IDLE_SEL;
            state_q     <= S_RESP;
          end else if (cnt_q == LAST_CNT) begin
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            rsp_tag_q   <= tag_q;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            sel_q       <= IDLE_SEL;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          sel_q       <= IDLE_SEL;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign inp_a     = a_q;
  assign inp_b     = b_q;
  assign fnct_sel  = sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`timescale 1ns/1ps
`default_nettype none
// tb_alu_issue : directed scenarios plus randomized traffic, checked every cycle
// against a transaction-level model of the issue stage.
module tb_alu_issue;
  localparam int         DATA_W      = 32;
  localparam int         SEL_W       = 9;
  localparam int         TAG_W       = 4;
  localparam int         TIMEOUT_CYC = 16;
  localparam logic [8:0] IDLE_SEL    = 9'h100;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [SEL_W-1:0]  req_fnct;
  logic [TAG_W-1:0]  req_tag;
  logic [DATA_W-1:0] inp_a;
  logic [DATA_W-1:0] inp_b;
  logic [SEL_W-1:0]  fnct_sel;
  logic              alu_ack;
  logic [DATA_W-1:0] out;
  logic              cf, nf, zf, vf;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [3:0]        rsp_flags;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_err;
  logic              busy;

  alu_issue #(
    .DATA_W(DATA_W), .SEL_W(SEL_W), .IDLE_SEL(IDLE_SEL), .TAG_W(TAG_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_fnct(req_fnct), .req_tag(req_tag),
    .inp_a(inp_a), .inp_b(inp_b), .fnct_sel(fnct_sel), .alu_ack(alu_ack),
    .out(out), .cf(cf), .nf(nf), .zf(zf), .vf(vf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Bench-side stimulus controls
  int          ack_delay;   // EXEC cycle (1-based) on which the ALU acks; 0 = never
  bit          spur;        // one-shot extra ack pulse
  bit          rnd_alu;
  logic [31:0] alu_out_v;
  logic [3:0]  alu_flg_v;

  // Transaction-level model: an op is either executing, waiting to be collected, or absent.
  bit          m_live, m_exec, m_pend;
  int          m_age, m_delay;
  logic [31:0] m_a, m_b, m_rd;
  logic [8:0]  m_f;
  logic [3:0]  m_t, m_rt, m_rf;
  logic        m_re;

  initial begin
    m_live = 0; m_exec = 0; m_pend = 0; m_age = 0; m_delay = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_live <= 1; m_exec <= 0; m_pend <= 0; m_age <= 0;
      m_a <= '0; m_b <= '0; m_f <= IDLE_SEL; m_t <= '0;
      m_rd <= '0; m_rf <= '0; m_rt <= '0; m_re <= 1'b0;
    end else if (m_live) begin
      if (m_pend) begin
        if (rsp_ready) m_pend <= 0;
      end else if (m_exec) begin
        m_age <= m_age + 1;
        if (alu_ack) begin
          m_exec <= 0; m_pend <= 1;
          m_rd <= out; m_rf <= {cf, nf, zf, vf}; m_rt <= m_t; m_re <= 1'b0;
        end else if (m_age + 1 == TIMEOUT_CYC) begin
          m_exec <= 0; m_pend <= 1;
          m_rd <= '0; m_rf <= '0; m_rt <= m_t; m_re <= 1'b1;
        end
      end else if (req_valid) begin
        m_exec <= 1; m_age <= 0; m_delay <= ack_delay;
        m_a <= req_a; m_b <= req_b; m_f <= req_fnct; m_t <= req_tag;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("req_ready", req_ready, !(m_exec || m_pend));
      chk("busy", busy, m_exec || m_pend);
      chk("rsp_valid", rsp_valid, m_pend);
      chk("inp_a", inp_a, m_a);
      chk("inp_b", inp_b, m_b);
      chk("fnct_sel", fnct_sel, m_exec ? m_f : IDLE_SEL);
      chk("rsp_data", rsp_data, m_rd);
      chk("rsp_flags", rsp_flags, m_rf);
      chk("rsp_tag", rsp_tag, m_rt);
      chk("rsp_err", rsp_err, m_re);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    alu_ack = spur || (m_exec && m_delay > 0 && m_age == m_delay - 1);
    spur = 0;
    if (rnd_alu) begin
      out = $urandom;
      {cf, nf, zf, vf} = 4'($urandom);
    end else begin
      out = alu_out_v;
      {cf, nf, zf, vf} = alu_flg_v;
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [8:0] f,
                       input logic [3:0] t, input int dly, input logic [31:0] o,
                       input logic [3:0] fl, input int hold, output int n_f, output int n_exec);
    req_a = a; req_b = b; req_fnct = f; req_tag = t; req_valid = 1'b1;
    ack_delay = dly; alu_out_v = o; alu_flg_v = fl; rsp_ready = (hold == 0);
    tick();
    req_valid = 1'b0;
    n_f = 0; n_exec = 0;
    for (int i = 0; i < 40 && rsp_valid !== 1'b1; i++) begin
      if (fnct_sel === f) n_f++;
      if (busy === 1'b1) n_exec++;
      tick();
    end
    chk("rsp_seen", rsp_valid, 1'b1);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_req_ready", req_ready, 1'b0);
    end
  endtask

  task automatic release_rsp(input string nm);
    rsp_ready = 1'b1;
    tick();
    chk({nm, "_busy_after"}, busy, 1'b0);
    chk({nm, "_ready_after"}, req_ready, 1'b1);
    chk({nm, "_valid_after"}, rsp_valid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nf_c, ne_c, last1, first2, rsp1_i, nr, nv;
    logic [3:0] rtag [4];
    bit acc;
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_fnct = '0; req_tag = '0;
    alu_ack = 1'b0; out = '0; {cf, nf, zf, vf} = 4'b0; rsp_ready = 1'b0;
    ack_delay = 0; spur = 0; rnd_alu = 0; alu_out_v = '0; alu_flg_v = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_fnct_sel", fnct_sel, 9'h100);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_inp_a", inp_a, 32'h0);
    chk("rst_busy", busy, 1'b0);

    // Basic op: ack on second EXEC cycle
    do_op(32'h8, 32'h4, 9'h040, 4'd3, 2, 32'hC, 4'b0000, 0, nf_c, ne_c);
    chk("basic_fnct_cycles", nf_c, 2);
    chk("basic_data", rsp_data, 32'hC);
    chk("basic_tag", rsp_tag, 4'd3);
    chk("basic_err", rsp_err, 1'b0);
    chk("basic_fnct_idle", fnct_sel, 9'h100);
    release_rsp("basic");

    // Backpressure
    do_op(32'h8, 32'h4, 9'h040, 4'd5, 2, 32'h0, 4'b0010, 5, nf_c, ne_c);
    chk("bp_data", rsp_data, 32'h0);
    chk("bp_flags", rsp_flags, 4'b0010);
    chk("bp_tag", rsp_tag, 4'd5);
    release_rsp("bp");

    // Timeout: ALU never acks
    do_op(32'h11, 32'h22, 9'h013, 4'd7, 0, 32'hDEAD, 4'hF, 0, nf_c, ne_c);
    chk("to_exec_cycles", ne_c, 16);
    chk("to_err", rsp_err, 1'b1);
    chk("to_data", rsp_data, 32'h0);
    chk("to_flags", rsp_flags, 4'h0);
    release_rsp("to");

    // Ack on the final EXEC cycle
    do_op(32'h1, 32'h2, 9'h014, 4'd9, 16, 32'h1234, 4'b1001, 0, nf_c, ne_c);
    chk("last_exec_cycles", ne_c, 16);
    chk("last_err", rsp_err, 1'b0);
    chk("last_data", rsp_data, 32'h1234);
    chk("last_flags", rsp_flags, 4'b1001);
    release_rsp("last");

    // Spurious ack in IDLE, then back-to-back requests
    spur = 1; tick(); tick();
    chk("spur_no_rsp", rsp_valid, 1'b0);
    chk("spur_idle", busy, 1'b0);
    req_valid = 1'b1; req_tag = 4'd1; req_fnct = 9'h001; ack_delay = 1; rsp_ready = 1'b1;
    alu_out_v = 32'h55; alu_flg_v = 4'b0100;
    last1 = -1; first2 = -1; rsp1_i = -1; nr = 0;
    for (int i = 0; i < 20; i++) begin
      acc = req_valid && !m_exec && !m_pend;
      tick();
      if (rsp_valid === 1'b1 && nr < 4) begin
        rtag[nr] = rsp_tag;
        if (rsp_tag === 4'd1) rsp1_i = i;
        nr++;
      end
      if (fnct_sel === 9'h001) last1 = i;
      if (fnct_sel === 9'h002 && first2 < 0) first2 = i;
      if (acc) begin
        if (req_tag == 4'd1) begin req_tag = 4'd2; req_fnct = 9'h002; end
        else req_valid = 1'b0;
      end
    end
    chk("b2b_rsp_count", nr, 2);
    chk("b2b_first_tag", rtag[0], 4'd1);
    chk("b2b_second_tag", rtag[1], 4'd2);
    chk("b2b_order", rsp1_i >= 0 && rsp1_i < first2, 1'b1);
    chk("b2b_idle_gap", last1 >= 0 && first2 - last1 >= 2, 1'b1);
    req_valid = 1'b0;

    // Reset mid-op, then a late ack
    req_a = 32'hA; req_b = 32'hB; req_fnct = 9'h033; req_tag = 4'd6; ack_delay = 6; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rmid_in_exec", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmid_busy", busy, 1'b0);
    chk("rmid_fnct", fnct_sel, 9'h100);
    chk("rmid_ready", req_ready, 1'b1);
    chk("rmid_valid", rsp_valid, 1'b0);
    spur = 1; nv = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid !== 1'b0) nv++;
    end
    chk("rmid_no_rsp", nv, 0);

    // Randomized traffic
    rnd_alu = 1;
    for (int c = 0; c < 4000; c++) begin
      acc = req_valid && !rst && !m_exec && !m_pend;
      tick();
      if (!req_valid || acc) begin
        req_valid = ($urandom % 3) != 0;
        req_a = $urandom; req_b = $urandom;
        req_fnct = 9'($urandom); req_tag = 4'($urandom);
        ack_delay = $urandom_range(0, 18);
      end
      rsp_ready = ($urandom % 3) != 0;
      spur = ($urandom % 10) == 0;
      rst = ($urandom % 200) == 0;
    end
    rst = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
